cnn_pipeline_ctrl: RTL and testbench

Parametrised frame controller for the CNN layer chain (image source → N conv/pool layers → result vector). Accepts frame-start requests, issues start pulses to the image source, and tracks frames in flight from the per-stage valid pulses. Captures each final-layer result into a small output queue with a valid/ready handshake. Flags stalled pipelines and dropped results.

---
 rtl/cnn_pkg.sv | 21 ++
 rtl/cnn_out_fifo.sv | 59 +++++
 rtl/cnn_pipeline_ctrl.sv | 121 ++++++++++++
 tb/tb_cnn_pipeline_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN frame controller.
//   state_e   : controller state (idle / frames in flight / error)
//   DEF_*     : default geometry of the layer chain
//   wd_width  : watchdog counter width for a given idle-cycle limit
package cnn_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StErr  = 2'd2
    } state_e;

    localparam int unsigned DEF_OUT_W    = 16;
    localparam int unsigned DEF_OUT_N    = 16;
    localparam int unsigned DEF_N_LAYERS = 4;

    function automatic int unsigned wd_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cnn_out_fifo.sv
// Two-entry result queue.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : empties the queue (priority over push/pop)
//   push/wdata : write request; taken when not full, or when full with a pop
//   pop        : read request; ignored when empty
//   rdata      : head entry, held while not popped
//   full/empty : occupancy flags
module cnn_out_fifo #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == 2'd2);
    assign empty   = (cnt_q == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) mem_q[i] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 2'd1;
                2'b01:   cnt_q <= cnt_q - 2'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/cnn_pipeline_ctrl.sv
// Frame controller for the CNN layer chain.
//   pic_start/start_ready : frame request handshake
//   src_start             : one-cycle start pulse to the image source
//   stage_valid           : per-stage valid pulses, bit N_LAYERS is the final layer
//   final_data            : final-layer result, captured on stage_valid[N_LAYERS]
//   out/out_valid/out_ready : result queue head with valid/ready handshake
//   clr_err               : clears errors and flushes the controller
//   busy/inflight/frame_cnt : status
//   err_timeout/err_overflow : sticky watchdog and dropped-result flags
module cnn_pipeline_ctrl
    import cnn_pkg::*;
#(
    parameter int unsigned N_LAYERS     = DEF_N_LAYERS,
    parameter int unsigned OUT_W        = DEF_OUT_W,
    parameter int unsigned OUT_N        = DEF_OUT_N,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pic_start,
    output logic                   start_ready,
    output logic                   src_start,
    input  logic [N_LAYERS:0]      stage_valid,
    input  logic [OUT_W*OUT_N-1:0] final_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W*OUT_N-1:0] out,
    input  logic                   clr_err,
    output logic                   busy,
    output logic [2:0]             inflight,
    output logic [15:0]            frame_cnt,
    output logic                   err_timeout,
    output logic                   err_overflow
);

    localparam int unsigned DW     = OUT_W * OUT_N;
    localparam int unsigned WD_W   = wd_width(TIMEOUT);
    localparam logic [2:0]  MAX_IF = 3'(MAX_INFLIGHT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [2:0]      inflight_q, inflight_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            src_start_q, start_ready_q, err_to_q, err_ov_q;
    logic [15:0]     frame_cnt_q;

    logic accept, fin, handshake, ovf_ev, to_ev, quiet_run;
    logic fifo_full, fifo_empty;

    cnn_out_fifo #(
        .WIDTH(DW)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .flush(clr_err),
        .push (fin),
        .pop  (out_ready),
        .wdata(final_data),
        .rdata(out),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_comb begin
        handshake = !fifo_empty && out_ready;
        accept    = pic_start && start_ready_q && !clr_err;
        // Final valid only counts with a frame in flight and outside ERR.
        fin       = stage_valid[N_LAYERS] && (state_q != StErr) &&
                    (inflight_q != 3'd0) && !clr_err;
        ovf_ev    = fin && fifo_full && !handshake;
        quiet_run = (state_q == StRun) && (stage_valid == '0);
        to_ev     = quiet_run && (wd_q == WD_LAST) && !clr_err;

        inflight_d = inflight_q;
        if (clr_err)              inflight_d = 3'd0;
        else if (accept && !fin)  inflight_d = inflight_q + 3'd1;
        else if (fin && !accept)  inflight_d = inflight_q - 3'd1;

        wd_d = (quiet_run && !clr_err && !to_ev) ? wd_q + WD_W'(1) : '0;

        if (clr_err)                state_d = StIdle;
        else if (to_ev || ovf_ev)   state_d = StErr;
        else if (state_q == StErr)  state_d = StErr;
        else if (inflight_d != 3'd0) state_d = StRun;
        else                        state_d = StIdle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            inflight_q    <= 3'd0;
            wd_q          <= '0;
            src_start_q   <= 1'b0;
            start_ready_q <= 1'b0;
            err_to_q      <= 1'b0;
            err_ov_q      <= 1'b0;
            frame_cnt_q   <= 16'd0;
        end else begin
            state_q       <= state_d;
            inflight_q    <= inflight_d;
            wd_q          <= wd_d;
            src_start_q   <= accept;
            // Built from next-state values so a fresh accept closes the window at once.
            start_ready_q <= (inflight_d < MAX_IF) && (state_d != StErr);
            err_to_q      <= !clr_err && (err_to_q || to_ev);
            err_ov_q      <= !clr_err && (err_ov_q || ovf_ev);
            if (handshake) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign start_ready  = start_ready_q;
    assign src_start    = src_start_q;
    assign out_valid    = !fifo_empty;
    assign busy         = (state_q == StRun);
    assign inflight     = inflight_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_timeout  = err_to_q;
    assign err_overflow = err_ov_q;

endmodule

// File: tb/tb_cnn_pipeline_ctrl.sv
module tb_cnn_pipeline_ctrl;

    localparam int NL   = 4;
    localparam int DW   = 256;
    localparam int MAXI = 2;
    localparam int TMO  = 40;
    localparam int M_IDLE = 0, M_RUN = 1, M_ERR = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pic_start = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_err = 1'b0;
    logic [NL:0]   stage_valid = '0;
    logic [DW-1:0] final_data = '0;
    logic          start_ready, src_start, out_valid, busy, err_timeout, err_overflow;
    logic [DW-1:0] out;
    logic [2:0]    inflight;
    logic [15:0]   frame_cnt;

    cnn_pipeline_ctrl #(
        .N_LAYERS    (NL),
        .OUT_W       (16),
        .OUT_N       (16),
        .MAX_INFLIGHT(MAXI),
        .TIMEOUT     (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pic_start   (pic_start),
        .start_ready (start_ready),
        .src_start   (src_start),
        .stage_valid (stage_valid),
        .final_data  (final_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .clr_err     (clr_err),
        .busy        (busy),
        .inflight    (inflight),
        .frame_cnt   (frame_cnt),
        .err_timeout (err_timeout),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame count, result queue and error flags.
    logic [DW-1:0] m_q[$];
    int m_inflight, m_wd, m_fc, m_mode;
    bit m_src, m_sr, m_et, m_eo;

    task automatic check_eq(input string tag, input logic [DW-1:0] got,
                            input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_inflight = 0; m_wd = 0; m_fc = 0; m_mode = M_IDLE;
        m_src = 0; m_sr = 0; m_et = 0; m_eo = 0;
    endtask

    task automatic check_outputs();
        check_eq("src_start", src_start, m_src);
        check_eq("start_ready", start_ready, m_sr);
        check_eq("busy", busy, m_mode == M_RUN);
        check_eq("inflight", inflight, m_inflight);
        check_eq("out_valid", out_valid, m_q.size() != 0);
        if (m_q.size() != 0) check_eq("out", out, m_q[0]);
        check_eq("frame_cnt", frame_cnt, m_fc);
        check_eq("err_timeout", err_timeout, m_et);
        check_eq("err_overflow", err_overflow, m_eo);
    endtask

    task automatic model_step();
        bit hs, acc, fin, ov, to, quiet;
        hs = (m_q.size() != 0) && out_ready;
        if (hs) m_fc = (m_fc + 1) % 65536;
        if (clr_err) begin
            m_q.delete();
            m_inflight = 0; m_wd = 0; m_et = 0; m_eo = 0; m_src = 0;
            m_mode = M_IDLE;
        end else begin
            acc   = pic_start && m_sr;
            fin   = stage_valid[NL] && (m_mode != M_ERR) && (m_inflight > 0);
            ov    = fin && (m_q.size() == 2) && !hs;
            quiet = (m_mode == M_RUN) && (stage_valid == 0);
            to    = quiet && (m_wd + 1 == TMO);
            m_wd  = (quiet && !to) ? m_wd + 1 : 0;
            if (hs) void'(m_q.pop_front());
            if (fin && !ov) m_q.push_back(final_data);
            m_inflight = m_inflight + int'(acc) - int'(fin);
            if (ov || to) m_mode = M_ERR;
            else if (m_mode != M_ERR) m_mode = (m_inflight > 0) ? M_RUN : M_IDLE;
            if (to) m_et = 1;
            if (ov) m_eo = 1;
            m_src = acc;
        end
        m_sr = (m_inflight < MAXI) && (m_mode != M_ERR);
    endtask

    task automatic step();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic [NL:0] sv, input bit rdy, input bit clr);
        pic_start = p; stage_valid = sv; out_ready = rdy; clr_err = clr;
        step();
    endtask

    function automatic logic [DW-1:0] pattern(input int base);
        logic [DW-1:0] r;
        for (int k = 0; k < 16; k++) r[k*16 +: 16] = 16'(base + k);
        return r;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_src_start"}, src_start, 0);
        check_eq({tag, "_start_ready"}, start_ready, 0);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out"}, out, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_inflight"}, inflight, 0);
        check_eq({tag, "_frame_cnt"}, frame_cnt, 0);
        check_eq({tag, "_err"}, {err_timeout, err_overflow}, 0);
    endtask

    localparam logic [NL:0] FIN = 1 << NL;

    initial begin
        int pulses, fc0, quiet_left;
        logic [NL:0] sv;
        logic [DW-1:0] fd;
        bit rdy_bias;

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        drive(0, 0, 0, 0);

        // Single frame through all stages
        final_data = pattern(0);
        drive(1, 0, 0, 0);
        check_eq("t1_src_pulse", src_start, 1);
        check_eq("t1_busy", busy, 1);
        for (int i = 0; i <= NL; i++) drive(0, (NL+1)'(1 << i), 0, 0);
        check_eq("t1_out_valid", out_valid, 1);
        check_eq("t1_out", out, pattern(0));
        drive(0, 0, 1, 0);
        drive(0, 0, 0, 0);

        // Held request limited by MAX_INFLIGHT
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 0);
            if (src_start) pulses++;
        end
        check_eq("t2_pulses", pulses, 2);
        check_eq("t2_closed", start_ready, 0);
        final_data = pattern(8);
        drive(0, FIN, 1, 0);
        check_eq("t2_reopen", start_ready, 1);
        drive(0, FIN, 1, 0);
        repeat (2) drive(0, 0, 1, 0);

        // Overflow with a stalled consumer, then drain in ERR
        fc0 = frame_cnt;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        final_data = pattern(16); drive(0, FIN, 0, 0);
        drive(1, 0, 0, 0);
        final_data = pattern(32); drive(0, FIN, 0, 0);
        final_data = pattern(48); drive(0, FIN, 0, 0);
        check_eq("t3_overflow", err_overflow, 1);
        check_eq("t3_not_busy", busy, 0);
        check_eq("t3_head", out, pattern(16));
        repeat (3) drive(0, 0, 1, 0);
        check_eq("t3_frames", frame_cnt, fc0 + 2);
        drive(0, 0, 0, 1);
        drive(0, 0, 0, 0);

        // Watchdog
        drive(1, 0, 0, 0);
        repeat (TMO) drive(0, 0, 0, 0);
        check_eq("t4_timeout", err_timeout, 1);
        check_eq("t4_closed", start_ready, 0);
        drive(0, 0, 0, 1);
        check_eq("t4_clr_inflight", inflight, 0);
        check_eq("t4_clr_valid", out_valid, 0);
        check_eq("t4_clr_flag", err_timeout, 0);
        drive(0, 0, 0, 0);

        // Accept and final in the same cycle
        drive(1, 0, 0, 0);
        final_data = pattern(64);
        drive(1, FIN, 0, 0);
        check_eq("t5_inflight", inflight, 1);
        check_eq("t5_queued", out_valid, 1);
        drive(0, FIN, 1, 0);
        repeat (3) drive(0, 0, 1, 0);

        // Reset mid-frame with a full queue
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        final_data = pattern(80); drive(0, FIN, 0, 0);
        drive(1, 0, 0, 0);
        final_data = pattern(96); drive(0, FIN, 0, 0);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        pic_start = 0; stage_valid = '0; out_ready = 0; clr_err = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic
        quiet_left = 0;
        rdy_bias = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 256 == 0) rdy_bias = ~rdy_bias;
            if (quiet_left > 0) begin
                sv = '0;
                quiet_left--;
            end else begin
                if ($urandom_range(199) == 0) quiet_left = TMO + 5;
                for (int b = 0; b <= NL; b++) sv[b] = ($urandom_range(3) == 0);
            end
            for (int w = 0; w < DW / 32; w++) fd[w*32 +: 32] = $urandom;
            final_data = fd;
            drive(($urandom_range(1) == 1), sv,
                  rdy_bias ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0),
                  (m_mode == M_ERR) ? ($urandom_range(7) == 0) : ($urandom_range(299) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
